// File: rtl/uart_tx_fifo.sv
// Byte-wide FIFO feeding an 8N1 UART transmitter (LSB first, idle-high line).
// The shifter pulls from the FIFO only when it starts a frame, so queued bytes go out back-to-back.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 8
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       busy,
  output logic       overflow,
  output logic       txd
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [12:0] DIV_M1  = 13'(CLK_FREQ / BAUD - 1);
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [12:0]     bit_cnt, bit_cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            txd_nxt;
  logic            pop;
  logic            wr_acc;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == 5'd0);
  assign busy   = (state != IDLE);
  assign wr_acc = wr_en && !full;

  // FIFO control: full is judged before the edge, so a write on the pop edge of a full FIFO is dropped
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      count <= count + {4'b0, wr_acc} - {4'b0, pop};
    end
  end

  always_ff @(posedge clk_50M) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // txd is registered from the next-state decode, so a line change lands on the transition edge
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    txd_nxt     = txd;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (!empty) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          bit_cnt_nxt = 13'd0;
          state_nxt   = START;
          txd_nxt     = 1'b0;
        end
      end
      START: begin
        if (bit_cnt == DIV_M1) begin
          bit_cnt_nxt = 13'd0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
          txd_nxt     = shift[0];
        end else begin
          bit_cnt_nxt = bit_cnt + 13'd1;
        end
      end
      DATA: begin
        if (bit_cnt == DIV_M1) begin
          bit_cnt_nxt = 13'd0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = 1'b1;
          end else begin
            shift_nxt   = shift >> 1;
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = shift[1];
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 13'd1;
        end
      end
      STOP: begin
        if (bit_cnt == DIV_M1) begin
          bit_cnt_nxt = 13'd0;
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            txd_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 13'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 13'd0;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      txd     <= txd_nxt;
    end
  end

  always_ff @(posedge clk_50M) begin
    shift <= shift_nxt;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=5 (CLK_FREQ=50, BAUD=10), DEPTH=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_tx_fifo;

  logic       clk_50M;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       overflow;
  logic       txd;

  int n_tests    = 0;
  int n_fail     = 0;
  int ovf_pulses = 0;
  int snap;

  uart_tx_fifo #(
    .CLK_FREQ(50),
    .BAUD    (10),
    .DEPTH   (8)
  ) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .overflow(overflow),
    .txd     (txd)
  );

  initial clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (overflow) ovf_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(txd), 64'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  // Expects to be called just after the edge that drove the start bit; samples all 50 line cycles.
  task automatic rx_frame(input logic [7:0] b, input string tag);
    logic [49:0] obs;
    logic [49:0] exp;
    logic [9:0]  bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 50; i++) begin
      exp[i] = bits[i / 5];
      obs[i] = txd;
      step();
    end
    chk(tag, 64'(obs), 64'(exp));
  endtask

  function automatic logic [7:0] ovd(input int k);
    return 8'(k * 37 + 21);
  endfunction

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(posedge clk_50M);
    #1;
    chk("rst_txd",   64'(txd),      64'd1);
    chk("rst_count", 64'(count),    64'd0);
    chk("rst_empty", 64'(empty),    64'd1);
    chk("rst_full",  64'(full),     64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    chk("rst_ovf",   64'(overflow), 64'd0);
    rst = 1'b0;
    step();

    // Single byte with latency check
    write_byte(8'hA5);
    chk("lat_txd_hi", 64'(txd),   64'd1);
    chk("lat_count1", 64'(count), 64'd1);
    chk("lat_busy0",  64'(busy),  64'd0);
    step();
    chk("lat_txd_lo", 64'(txd),   64'd0);
    chk("lat_busy1",  64'(busy),  64'd1);
    chk("lat_count0", 64'(count), 64'd0);
    rx_frame(8'hA5, "single_frame");
    chk("single_busy",  64'(busy),  64'd0);
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_txd",   64'(txd),   64'd1);

    // Back-to-back frames with no idle gap
    write_byte(8'h00);
    write_byte(8'hFF);
    chk("b2b_start", 64'(txd), 64'd0);
    rx_frame(8'h00, "b2b_frame0");
    rx_frame(8'hFF, "b2b_frame1");
    chk("b2b_busy", 64'(busy), 64'd0);

    // Overflow: ten writes in a row while idle
    step();
    snap = ovf_pulses;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          wr_en   = 1'b1;
          wr_data = ovd(k);
          step();
          if (k == 8) begin
            chk("ovf_count8", 64'(count), 64'd8);
            chk("ovf_full",   64'(full),  64'd1);
          end
          if (k == 9) begin
            chk("ovf_pulse",  64'(overflow), 64'd1);
            chk("ovf_count9", 64'(count),    64'd8);
          end
        end
        wr_en = 1'b0;
        step();
        chk("ovf_pulse_end", 64'(overflow), 64'd0);
      end
      begin
        wait_start(10, "ovf_start");
        for (int j = 0; j < 9; j++) rx_frame(ovd(j), "ovf_frame");
      end
    join
    chk("ovf_n_pulses", 64'(ovf_pulses - snap), 64'd1);
    chk("ovf_busy",     64'(busy),  64'd0);
    chk("ovf_count0",   64'(count), 64'd0);

    // Write on the pop edge of a full FIFO is dropped; one cycle later it is accepted
    for (int k = 0; k < 9; k++) write_byte(8'(8'h40 + k));
    chk("sim_count8", 64'(count), 64'd8);
    chk("sim_full",   64'(full),  64'd1);
    repeat (42) @(posedge clk_50M);
    #1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    chk("sim_ovf",    64'(overflow), 64'd1);
    chk("sim_count7", 64'(count),    64'd7);
    chk("sim_start",  64'(txd),      64'd0);
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    chk("sim_count_back", 64'(count),    64'd8);
    chk("sim_ovf_end",    64'(overflow), 64'd0);
    wait_idle(700, "sim_drain");
    chk("sim_empty", 64'(empty), 64'd1);

    // Reset during data bit 3, with wr_en held high under reset
    write_byte(8'hA5);
    write_byte(8'h3C);
    repeat (21) @(posedge clk_50M);
    #1;
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    rst   = 1'b0;
    wr_en = 1'b0;
    chk("abort_txd",   64'(txd),      64'd1);
    chk("abort_count", 64'(count),    64'd0);
    chk("abort_busy",  64'(busy),     64'd0);
    chk("abort_empty", 64'(empty),    64'd1);
    chk("abort_ovf",   64'(overflow), 64'd0);
    repeat (3) step();
    chk("abort_quiet", 64'({busy, txd}), 64'd1);
    write_byte(8'h5A);
    wait_start(5, "abort_new_start");
    rx_frame(8'h5A, "abort_new_frame");
    chk("abort_new_busy", 64'(busy), 64'd0);

    // Pointer wrap: twenty spaced single writes
    for (int k = 0; k < 20; k++) begin
      write_byte(8'(k * 53 + 7));
      wait_start(5, "wrap_start");
      rx_frame(8'(k * 53 + 7), "wrap_frame");
    end
    chk("wrap_empty", 64'(empty), 64'd1);
    chk("wrap_busy",  64'(busy),  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
